// File: rtl/sram_bus_pkg.sv
// Shared types for the single-ported SRAM arbiter: FSM state encoding,
// access owner, and the default SRAM read latency.
package sram_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned RD_LAT_DEF = 1;

endpackage

// File: rtl/arb2_rr.sv
// Two-way grant selector between the instruction and data requesters.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   ins_req_i      instruction requester active
//   data_req_i     data requester active
//   grant_en_i     the grant is being consumed this cycle (updates last_grant)
//   grant_o        selected owner (combinational)
// DATA_PRIO=1: data wins every conflict. DATA_PRIO=0: a conflict goes to the
// requester not granted last; last_grant resets to the instruction side.
module arb2_rr
  import sram_bus_pkg::*;
#(
  parameter int unsigned DATA_PRIO = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ins_req_i,
  input  logic   data_req_i,
  input  logic   grant_en_i,
  output owner_e grant_o
);

  owner_e last_q;
  owner_e last_d;

  // Lone requester always wins; a conflict is resolved by mode.
  always_comb begin
    grant_o = OWN_I;
    if (data_req_i && !ins_req_i) begin
      grant_o = OWN_D;
    end else if (data_req_i && ins_req_i) begin
      if ((DATA_PRIO != 0) || (last_q == OWN_I)) begin
        grant_o = OWN_D;
      end else begin
        grant_o = OWN_I;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant_en_i) begin
      last_d = grant_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between instruction fetch and
// the data (MEM-stage) requester, hiding the fixed SRAM read latency.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ins_req/ins_addr              instruction read request (held while stalled)
//   ins_rdata/ins_stall           instruction read data / hold
//   data_req/data_wen             data read request / byte write enables
//   data_addr/data_wdata          data address / write data
//   data_rdata/data_stall         data read data / hold
//   sram_en/sram_wen/sram_addr/sram_wdata/sram_rdata   SRAM macro port
// Each access: one issue cycle in IDLE, then RD_LAT busy cycles, the last of
// which is the completion cycle. SRAM port outputs are combinational.
module sram_port_arbiter
  import sram_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = RD_LAT_DEF,
  parameter int unsigned DATA_PRIO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_req,
  input  logic [ADDR_W-1:0]   ins_addr,
  output logic [DATA_W-1:0]   ins_rdata,
  output logic                ins_stall,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_stall,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             data_act;
  logic             issue;
  logic             done;
  owner_e           grant;

  assign data_act = data_req | (|data_wen);
  assign done     = (state_q != IDLE) && (cnt_q == CNT_W'(1));
  // Gating with rst keeps the SRAM port quiet for the whole reset assertion.
  assign issue    = rst && (state_q == IDLE) && (ins_req || data_act);

  arb2_rr #(
    .DATA_PRIO (DATA_PRIO)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .ins_req_i  (ins_req),
    .data_req_i (data_act),
    .grant_en_i (issue),
    .grant_o    (grant)
  );

  // Next state, latency counter and SRAM port muxing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sram_en    = 1'b0;
    sram_wen   = BE_W'(0);
    sram_addr  = ins_addr;
    sram_wdata = data_wdata;
    case (state_q)
      IDLE: begin
        if (issue) begin
          sram_en = 1'b1;
          cnt_d   = CNT_W'(RD_LAT);
          if (grant == OWN_D) begin
            sram_addr = data_addr;
            sram_wen  = data_wen;
            state_d   = BUSY_D;
          end else begin
            state_d   = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_W'(0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the owner's completion cycle releases its stall.
  assign ins_stall  = ins_req  & ~((state_q == BUSY_I) & (cnt_q == CNT_W'(1)));
  assign data_stall = data_act & ~((state_q == BUSY_D) & (cnt_q == CNT_W'(1)));
  assign ins_rdata  = sram_rdata;
  assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances share stimulus
//   k=0: RD_LAT=1, DATA_PRIO=1   k=1: RD_LAT=1, DATA_PRIO=0   k=2: RD_LAT=3, DATA_PRIO=1
// each with its own latency-matched SRAM read model.
module tb_sram_port_arbiter;

  typedef struct {
    int          cyc;
    bit          own_d;
    bit          chk;
    logic [31:0] rdata;
  } exp_t;

  localparam logic [31:0] A1 = 32'h0000_1000;
  localparam logic [31:0] A2 = 32'h8000_0040;
  localparam logic [31:0] A3 = 32'h8000_0100;
  localparam logic [31:0] A4 = 32'h8000_0200;
  localparam logic [31:0] A5 = 32'h0000_2004;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_req;
  logic [31:0] ins_addr;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;

  logic [31:0] ins_rdata  [3];
  logic        ins_stall  [3];
  logic [31:0] data_rdata [3];
  logic        data_stall [3];
  logic        sram_en    [3];
  logic [3:0]  sram_wen   [3];
  logic [31:0] sram_addr  [3];
  logic [31:0] sram_wdata [3];
  logic [31:0] sram_rdata [3];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   mon_k = -1;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_BFC0;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    logic [31:0] pipe [3];

    sram_port_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .RD_LAT    ((k == 2) ? 3 : 1),
      .DATA_PRIO ((k == 1) ? 0 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ins_req    (ins_req),
      .ins_addr   (ins_addr),
      .ins_rdata  (ins_rdata[k]),
      .ins_stall  (ins_stall[k]),
      .data_req   (data_req),
      .data_wen   (data_wen),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata[k]),
      .data_stall (data_stall[k]),
      .sram_en    (sram_en[k]),
      .sram_wen   (sram_wen[k]),
      .sram_addr  (sram_addr[k]),
      .sram_wdata (sram_wdata[k]),
      .sram_rdata (sram_rdata[k])
    );

    // SRAM read model: data for the address seen at an edge appears RD_LAT cycles later.
    always @(posedge clk) begin
      pipe[0] <= rd_of(sram_addr[k]);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign sram_rdata[k] = pipe[(k == 2) ? 2 : 0];
  end

  // Scoreboard: every completion of the watched instance pops one expectation.
  logic        m_ins_done;
  logic        m_dat_done;
  logic [31:0] m_rdata;
  exp_t        m_e;
  always @(negedge clk) begin
    if (mon_k >= 0 && rst === 1'b1) begin
      m_ins_done = ins_req && !ins_stall[mon_k];
      m_dat_done = (data_req || data_wen != 4'h0) && !data_stall[mon_k];
      if (m_ins_done || m_dat_done) begin
        checks++;
        m_rdata = m_dat_done ? data_rdata[mon_k] : ins_rdata[mon_k];
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected k=%0d cyc=%0d own_d=%0b", mon_k, cyc, m_dat_done);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.cyc != cyc || m_e.own_d != m_dat_done || m_ins_done == m_dat_done ||
              (m_e.chk && m_rdata !== m_e.rdata)) begin
            failures++;
            $display("FAIL sb_completion k=%0d got cyc=%0d own_d=%0b rdata=%h exp cyc=%0d own_d=%0b rdata=%h",
                     mon_k, cyc, m_dat_done, m_rdata, m_e.cyc, m_e.own_d, m_e.rdata);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b0; ins_req = 1'b0; data_req = 1'b0; data_wen = 4'h0;
    ins_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mon_k = -1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    ins_req = 1'b1; data_req = 1'b1; ins_addr = A1; data_addr = A2;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sram_en[k] !== 1'b0 || sram_wen[k] !== 4'h0) begin
        failures++;
        $display("FAIL reset_port k=%0d got en=%b wen=%h exp en=0 wen=0", k, sram_en[k], sram_wen[k]);
      end
      checks++;
      if (ins_stall[k] !== 1'b1 || data_stall[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_stall_raw k=%0d got %b%b exp 11", k, ins_stall[k], data_stall[k]);
      end
    end
    ins_req = 1'b0; data_req = 1'b0;
    #1;
    checks++;
    if (ins_stall[0] !== 1'b0 || data_stall[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall_idle got %b%b exp 00", ins_stall[0], data_stall[0]);
    end
  endtask

  task automatic test_ins_read();
    int c0;
    apply_reset(); mon_k = 0;
    @(posedge clk); #1; c0 = cyc;
    ins_req = 1'b1; ins_addr = 32'hBFC0_0000;
    exp_q.push_back('{c0 + 1, 1'b0, 1'b1, 32'h3C1D_BFC0});
    @(negedge clk);
    checks++;
    if (sram_en[0] !== 1'b1 || sram_addr[0] !== 32'hBFC0_0000 || sram_wen[0] !== 4'h0 || ins_stall[0] !== 1'b1) begin
      failures++;
      $display("FAIL ins_issue got en=%b addr=%h wen=%h stall=%b exp en=1 addr=bfc00000 wen=0 stall=1",
               sram_en[0], sram_addr[0], sram_wen[0], ins_stall[0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ins_stall[0] !== 1'b0 || sram_en[0] !== 1'b0) begin
      failures++;
      $display("FAIL ins_complete got stall=%b en=%b exp stall=0 en=0", ins_stall[0], sram_en[0]);
    end
    @(posedge clk); #1; ins_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL ins_sb_left got %0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_conflict_prio();
    int c0;
    apply_reset(); mon_k = 0;
    @(posedge clk); #1; c0 = cyc;
    ins_req = 1'b1; ins_addr = A1; data_req = 1'b1; data_addr = A2;
    exp_q.push_back('{c0 + 1, 1'b1, 1'b1, rd_of(A2)});
    exp_q.push_back('{c0 + 3, 1'b0, 1'b1, rd_of(A1)});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 2) data_req = 1'b0;
      @(negedge clk);
      checks++;
      if (ins_stall[0] !== 1'(i < 3) || data_stall[0] !== 1'(i == 0)) begin
        failures++;
        $display("FAIL prio_stall i=%0d got ins=%b data=%b exp ins=%b data=%b",
                 i, ins_stall[0], data_stall[0], 1'(i < 3), 1'(i == 0));
      end
      checks++;
      if (sram_en[0] !== 1'(i == 0 || i == 2) ||
          ((i == 0 || i == 2) && sram_addr[0] !== ((i == 0) ? A2 : A1))) begin
        failures++;
        $display("FAIL prio_issue i=%0d got en=%b addr=%h", i, sram_en[0], sram_addr[0]);
      end
    end
    @(posedge clk); #1; ins_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL prio_sb_left got %0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_write();
    int c0;
    apply_reset(); mon_k = 0;
    @(posedge clk); #1; c0 = cyc;
    data_wen = 4'b0010; data_addr = 32'h8000_0004; data_wdata = 32'h0000_AB00;
    exp_q.push_back('{c0 + 1, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    checks++;
    if (sram_en[0] !== 1'b1 || sram_wen[0] !== 4'b0010 || sram_addr[0] !== 32'h8000_0004 ||
        sram_wdata[0] !== 32'h0000_AB00 || data_stall[0] !== 1'b1) begin
      failures++;
      $display("FAIL wr_issue got en=%b wen=%h addr=%h wdata=%h stall=%b exp 1 2 80000004 0000ab00 1",
               sram_en[0], sram_wen[0], sram_addr[0], sram_wdata[0], data_stall[0]);
    end
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) data_wen = 4'h0;
      @(negedge clk);
      checks++;
      if (sram_en[0] !== 1'b0 || sram_wen[0] !== 4'h0 || data_stall[0] !== 1'b0) begin
        failures++;
        $display("FAIL wr_after i=%0d got en=%b wen=%h stall=%b exp 0 0 0", i, sram_en[0], sram_wen[0], data_stall[0]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wr_sb_left got %0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int c0;
    apply_reset(); mon_k = 1;
    @(posedge clk); #1; c0 = cyc;
    ins_req = 1'b1; ins_addr = A1; data_req = 1'b1; data_addr = A2;
    exp_q.push_back('{c0 + 1, 1'b1, 1'b1, rd_of(A2)});
    exp_q.push_back('{c0 + 3, 1'b0, 1'b1, rd_of(A1)});
    exp_q.push_back('{c0 + 5, 1'b1, 1'b1, rd_of(A2)});
    exp_q.push_back('{c0 + 7, 1'b0, 1'b1, rd_of(A1)});
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (sram_en[1] !== 1'(i % 2 == 0) ||
          ((i % 2 == 0) && sram_addr[1] !== ((i % 4 == 0) ? A2 : A1))) begin
        failures++;
        $display("FAIL rr_grant i=%0d got en=%b addr=%h exp en=%b addr=%h",
                 i, sram_en[1], sram_addr[1], 1'(i % 2 == 0), (i % 4 == 0) ? A2 : A1);
      end
      checks++;
      if (ins_stall[1] !== 1'(!(i == 3 || i == 7)) || data_stall[1] !== 1'(!(i == 1 || i == 5))) begin
        failures++;
        $display("FAIL rr_stall i=%0d got ins=%b data=%b", i, ins_stall[1], data_stall[1]);
      end
    end
    @(posedge clk); #1; ins_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rr_sb_left got %0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_latency3();
    int c0;
    apply_reset(); mon_k = 2;
    @(posedge clk); #1; c0 = cyc;
    data_req = 1'b1; data_addr = A3;
    exp_q.push_back('{c0 + 3, 1'b1, 1'b1, rd_of(A3)});
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 4) begin
        data_req = 1'b0; ins_req = 1'b1; ins_addr = A5;
        exp_q.push_back('{c0 + 7, 1'b0, 1'b1, rd_of(A5)});
      end
      @(negedge clk);
      checks++;
      if (sram_en[2] !== 1'(i == 0 || i == 4) || (i == 4 && sram_addr[2] !== A5)) begin
        failures++;
        $display("FAIL lat3_issue i=%0d got en=%b addr=%h", i, sram_en[2], sram_addr[2]);
      end
      checks++;
      if (data_stall[2] !== 1'(i < 3) || ins_stall[2] !== 1'(i >= 4 && i < 7)) begin
        failures++;
        $display("FAIL lat3_stall i=%0d got data=%b ins=%b exp data=%b ins=%b",
                 i, data_stall[2], ins_stall[2], 1'(i < 3), 1'(i >= 4 && i < 7));
      end
    end
    @(posedge clk); #1; ins_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL lat3_sb_left got %0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midaccess();
    int r0;
    apply_reset(); mon_k = 0;
    @(posedge clk); #1;
    data_req = 1'b1; data_addr = A4;
    @(negedge clk);
    checks++;
    if (sram_en[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_issue got en=%b exp 1", sram_en[0]);
    end
    // k=0 is now in its BUSY_D completion cycle, k=2 mid-access.
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (data_stall[0] !== 1'b1 || sram_en[0] !== 1'b0 || sram_en[2] !== 1'b0 || sram_wen[0] !== 4'h0) begin
      failures++;
      $display("FAIL rst_async got stall=%b en0=%b en2=%b wen=%h exp 1 0 0 0",
               data_stall[0], sram_en[0], sram_en[2], sram_wen[0]);
    end
    @(posedge clk); #1;
    rst = 1'b1; r0 = cyc;
    exp_q.push_back('{r0 + 1, 1'b1, 1'b1, rd_of(A4)});
    @(negedge clk);
    checks++;
    if (sram_en[0] !== 1'b1 || sram_addr[0] !== A4 || data_stall[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_reissue got en=%b addr=%h stall=%b exp 1 %h 1", sram_en[0], sram_addr[0], data_stall[0], A4);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (data_stall[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_reissue_done got stall=%b exp 0", data_stall[0]);
    end
    @(posedge clk); #1; data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_sb_left got %0d exp 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b0; ins_req = 1'b0; data_req = 1'b0; data_wen = 4'h0;
    ins_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ins_read();
    test_conflict_prio();
    test_write();
    test_round_robin();
    test_latency3();
    test_reset_midaccess();
    mon_k = -1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
